// File: rtl/writeback_pkg.sv
// Shared widths, state encoding and the latched execute-result record for the commit stage.
package writeback_pkg;
  localparam int WORD            = 16;
  localparam int MEM_TIMEOUT_DEF = 8;

  // Status register flag bit positions
  localparam int Zf = 0;
  localparam int Cf = 1;
  localparam int Nf = 2;
  localparam int If = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    COMMIT   = 2'd2,
    DONE     = 2'd3
  } wb_state_t;

  typedef struct packed {
    logic            reg_wb;
    logic            flag_update;
    logic            jump;
    logic [2:0]      reg_code;
    logic [WORD-1:0] reg_val;
    logic [WORD-1:0] mem_addr;
    logic [WORD-1:0] mem_val;
    logic [WORD-1:0] sreg;
    logic [WORD-1:0] jump_loc;
    logic [WORD-1:0] jump_inc;
  } exe_res_t;
endpackage

// File: rtl/writeback.sv
// Commit stage: latches one execute result, performs the memory write, commits RF/SREG/PC.
// Latency: wb_done 2 cycles after exe_valid for register-only ops, 2 cycles after mem_ack for memory ops.
// Backpressure: single entry; exe_valid while busy is dropped and flagged on the sticky overrun output.
module writeback
  import writeback_pkg::*;
#(
  parameter logic [WORD-1:0] PC_RESET    = '0,
  parameter int              MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exe_valid,
  input  logic            reg_wb,
  input  logic            mem_wb,
  input  logic            flag_update,
  input  logic            jump,
  input  logic [2:0]      reg_write_code,
  input  logic [WORD-1:0] reg_write_val,
  input  logic [WORD-1:0] mem_write_addr,
  input  logic [WORD-1:0] mem_write_val,
  input  logic [WORD-1:0] SREG_in,
  input  logic [WORD-1:0] PC_jump_loc,
  input  logic [WORD-1:0] PC_jump_inc,
  output logic            rf_we,
  output logic [2:0]      rf_waddr,
  output logic [WORD-1:0] rf_wdata,
  output logic            mem_req,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic            mem_ack,
  output logic [WORD-1:0] PC,
  output logic [WORD-1:0] SREG,
  output logic            wb_done,
  output logic            busy,
  output logic            mem_err,
  output logic            overrun
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  wb_state_t       state, state_nxt;
  exe_res_t        res;
  logic [CW-1:0]   tcnt, tcnt_nxt;
  logic            err_set;

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        tcnt_nxt = '0;
        if (exe_valid) state_nxt = mem_wb ? MEM_WAIT : COMMIT;
      end
      MEM_WAIT: begin
        // An ack on the last permitted cycle still counts as a clean write.
        if (mem_ack) begin
          state_nxt = COMMIT;
        end else if (tcnt == CW'(MEM_TIMEOUT - 1)) begin
          err_set   = 1'b1;
          state_nxt = COMMIT;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      COMMIT:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      res     <= '0;
      tcnt    <= '0;
      PC      <= PC_RESET;
      SREG    <= '0;
      mem_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      if (state == IDLE && exe_valid) begin
        res.reg_wb      <= reg_wb;
        res.flag_update <= flag_update;
        res.jump        <= jump;
        res.reg_code    <= reg_write_code;
        res.reg_val     <= reg_write_val;
        res.mem_addr    <= mem_write_addr;
        res.mem_val     <= mem_write_val;
        res.sreg        <= SREG_in;
        res.jump_loc    <= PC_jump_loc;
        res.jump_inc    <= PC_jump_inc;
      end
      if (state != IDLE && exe_valid) overrun <= 1'b1;
      if (err_set) mem_err <= 1'b1;
      if (state == COMMIT) begin
        if (res.flag_update) SREG <= res.sreg;
        PC <= res.jump ? res.jump_loc : PC + res.jump_inc;
      end
    end
  end

  assign rf_we     = (state == COMMIT) && res.reg_wb;
  assign rf_waddr  = res.reg_code;
  assign rf_wdata  = res.reg_val;
  assign mem_req   = (state == MEM_WAIT);
  assign mem_addr  = res.mem_addr;
  assign mem_wdata = res.mem_val;
  assign wb_done   = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: table-driven ops checked through an expectation queue, plus reset/ack corner sequences.
module tb_writeback;
  import writeback_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            exe_valid, reg_wb, mem_wb, flag_update, jump;
  logic [2:0]      reg_write_code;
  logic [WORD-1:0] reg_write_val, mem_write_addr, mem_write_val, SREG_in, PC_jump_loc, PC_jump_inc;
  logic            rf_we, mem_req, mem_ack, wb_done, busy, mem_err, overrun;
  logic [2:0]      rf_waddr;
  logic [WORD-1:0] rf_wdata, mem_addr, mem_wdata, PC, SREG;

  writeback dut (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .reg_wb(reg_wb), .mem_wb(mem_wb),
    .flag_update(flag_update), .jump(jump), .reg_write_code(reg_write_code),
    .reg_write_val(reg_write_val), .mem_write_addr(mem_write_addr), .mem_write_val(mem_write_val),
    .SREG_in(SREG_in), .PC_jump_loc(PC_jump_loc), .PC_jump_inc(PC_jump_inc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .PC(PC), .SREG(SREG),
    .wb_done(wb_done), .busy(busy), .mem_err(mem_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, mw, fu, jp;
    logic [2:0]  code;
    logic [15:0] rval, maddr, mval, sreg, loc, inc;
    int          ack_dly;   // mem_req cycle in which ack is driven; 0 = never
    int          ovr_at;    // cycle to inject a stray exe_valid; 0 = none
    logic [15:0] exp_pc, exp_sreg;
    logic        exp_err, exp_ovr;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [2:0]  code;
    logic [15:0] rval, pc, sreg;
    logic        err, ovr;
    int          lat, reqs;
  } exp_t;

  vec_t tbl[12];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic rw, mw, fu, jp, input logic [2:0] code,
                              input logic [15:0] rval, maddr, mval, sreg, loc, inc,
                              input int ack_dly, ovr_at, input logic [15:0] pc, sr,
                              input logic err, ovr);
    vec_t v;
    v.rw = rw; v.mw = mw; v.fu = fu; v.jp = jp; v.code = code;
    v.rval = rval; v.maddr = maddr; v.mval = mval; v.sreg = sreg; v.loc = loc; v.inc = inc;
    v.ack_dly = ack_dly; v.ovr_at = ovr_at;
    v.exp_pc = pc; v.exp_sreg = sr; v.exp_err = err; v.exp_ovr = ovr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    exe_valid = 0; reg_wb = 0; mem_wb = 0; flag_update = 0; jump = 0; reg_write_code = '0;
    reg_write_val = '0; mem_write_addr = '0; mem_write_val = '0; SREG_in = '0;
    PC_jump_loc = '0; PC_jump_inc = '0; mem_ack = 0;
  endtask

  task automatic run_op(input int idx);
    vec_t v;
    exp_t e;
    exp_t got;
    int   cyc = 0;
    int   req_cnt = 0;
    bit   done = 0;
    bit   rf_seen = 0;
    v = tbl[idx];
    clear_bus();
    reg_wb = v.rw; mem_wb = v.mw; flag_update = v.fu; jump = v.jp; reg_write_code = v.code;
    reg_write_val = v.rval; mem_write_addr = v.maddr; mem_write_val = v.mval; SREG_in = v.sreg;
    PC_jump_loc = v.loc; PC_jump_inc = v.inc;
    exe_valid = 1;
    e.rw = v.rw; e.code = v.code; e.rval = v.rval; e.pc = v.exp_pc; e.sreg = v.exp_sreg;
    e.err = v.exp_err; e.ovr = v.exp_ovr;
    e.reqs = v.mw ? ((v.ack_dly > 0) ? v.ack_dly : 8) : 0;
    e.lat  = e.reqs + 2;
    sb.push_back(e);
    while (!done && cyc < 60) begin
      tick();
      cyc++;
      exe_valid = 0;
      mem_ack = 0;
      if (cyc == v.ovr_at) begin
        mem_write_addr = 16'h00FF; mem_write_val = 16'h0000; reg_write_code = 3'd1;
        reg_write_val = 16'h1111; jump = 1; PC_jump_loc = 16'hAAAA;
        exe_valid = 1;
      end
      if (mem_req) begin
        req_cnt++;
        chk($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.maddr));
        chk($sformatf("v%0d mem_wdata", idx), 32'(mem_wdata), 32'(v.mval));
        if (req_cnt == v.ack_dly) mem_ack = 1;
      end
      if (rf_we) begin
        rf_seen = 1;
        chk($sformatf("v%0d rf_waddr", idx), 32'(rf_waddr), 32'(sb[0].code));
        chk($sformatf("v%0d rf_wdata", idx), 32'(rf_wdata), 32'(sb[0].rval));
      end
      if (wb_done) begin
        done = 1;
        got = sb.pop_front();
        chk($sformatf("v%0d PC", idx), 32'(PC), 32'(got.pc));
        chk($sformatf("v%0d SREG", idx), 32'(SREG), 32'(got.sreg));
        chk($sformatf("v%0d mem_err", idx), 32'(mem_err), 32'(got.err));
        chk($sformatf("v%0d overrun", idx), 32'(overrun), 32'(got.ovr));
        chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(got.lat));
        chk($sformatf("v%0d req_cycles", idx), 32'(req_cnt), 32'(got.reqs));
        chk($sformatf("v%0d rf_we_seen", idx), 32'(rf_seen), 32'(got.rw));
      end
    end
    if (!done) begin
      chk($sformatf("v%0d wb_done_timeout", idx), 32'(0), 32'(1));
      sb.delete();
    end
    clear_bus();
    tick();
    chk($sformatf("v%0d busy_after", idx), 32'(busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    //            rw mw fu jp code rval      maddr     mval      sreg      loc       inc       ack ovr pc        sreg      err ovr
    tbl[0]  = mk(1, 0, 1, 0, 3'd3, 16'd42,   16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0002, 0, 0, 16'h0002, 16'h0002, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 3'd0, 16'h0000, 16'h0040, 16'h1234, 16'h0000, 16'h0000, 16'h0002, 3, 0, 16'h0004, 16'h0002, 0, 0);
    tbl[2]  = mk(0, 0, 1, 1, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h0010, 16'h0004, 0, 0, 16'h0010, 16'h0005, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 3'd7, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 0, 0, 16'h000E, 16'h0005, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 0, 0, 16'h0001, 16'h0005, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 0, 0, 16'hFFFF, 16'h0005, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 0, 0, 16'h0000, 16'h0005, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0, 3'd0, 16'h0000, 16'h0100, 16'h00AA, 16'h0000, 16'h0000, 16'h0002, 0, 0, 16'h0002, 16'h0005, 1, 0);
    tbl[8]  = mk(1, 1, 1, 0, 3'd1, 16'h7777, 16'h0200, 16'h5555, 16'h000F, 16'h0000, 16'h0002, 1, 0, 16'h0004, 16'h000F, 1, 0);
    tbl[9]  = mk(0, 1, 0, 0, 3'd0, 16'h0000, 16'h0210, 16'h6666, 16'h0000, 16'h0000, 16'h0002, 8, 0, 16'h0006, 16'h000F, 1, 0);
    tbl[10] = mk(1, 1, 0, 0, 3'd5, 16'h0555, 16'h0080, 16'hBEEF, 16'h0000, 16'h0000, 16'h0002, 4, 2, 16'h0008, 16'h000F, 1, 1);
    tbl[11] = mk(1, 1, 0, 0, 3'd2, 16'h00C3, 16'h0300, 16'h0001, 16'h0000, 16'h0000, 16'h0006, 2, 0, 16'h0006, 16'h0000, 0, 0);

    clear_bus();
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("rst PC", 32'(PC), 32'(16'h0000));
    chk("rst SREG", 32'(SREG), 32'(0));
    chk("rst rf_we", 32'(rf_we), 32'(0));
    chk("rst mem_req", 32'(mem_req), 32'(0));
    chk("rst wb_done", 32'(wb_done), 32'(0));
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst mem_err", 32'(mem_err), 32'(0));
    chk("rst overrun", 32'(overrun), 32'(0));
    chk("rst mem_addr", 32'(mem_addr), 32'(0));
    chk("rst rf_wdata", 32'(rf_wdata), 32'(0));

    for (int i = 0; i <= 10; i++) run_op(i);

    // Reset while a memory write is outstanding must abandon it without committing anything.
    clear_bus();
    reg_wb = 1; mem_wb = 1; flag_update = 1; jump = 1; reg_write_code = 3'd4;
    reg_write_val = 16'h4444; mem_write_addr = 16'h0400; SREG_in = 16'hFFFF; PC_jump_loc = 16'h1234;
    exe_valid = 1;
    tick();
    exe_valid = 0;
    chk("rstmw mem_req_before", 32'(mem_req), 32'(1));
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rstmw mem_req", 32'(mem_req), 32'(0));
    chk("rstmw PC", 32'(PC), 32'(16'h0000));
    chk("rstmw SREG", 32'(SREG), 32'(0));
    chk("rstmw busy", 32'(busy), 32'(0));
    chk("rstmw mem_err", 32'(mem_err), 32'(0));
    chk("rstmw overrun", 32'(overrun), 32'(0));
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rf_we || wb_done || mem_req) hits++;
    end
    chk("rstmw no_commit", 32'(hits), 32'(0));

    // A stray ack while idle must not start anything.
    clear_bus();
    mem_ack = 1;
    tick();
    tick();
    chk("idle_ack busy", 32'(busy), 32'(0));
    chk("idle_ack mem_req", 32'(mem_req), 32'(0));
    mem_ack = 0;

    run_op(11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
